// File: rtl/alu_ctrl.sv
// Multi-pass sequencer for an external combinational 8-bit ALU: accepts one
// command, feeds the ALU result back into operand A for cnt+1 passes, then holds the result.
module alu_ctrl #(
    parameter int CNT_W = 3
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             cmd_valid_in,
    output logic             cmd_ready_out,
    input  logic [4:0]       cmd_op_in,
    input  logic             cmd_carry_in,
    input  logic [7:0]       cmd_a_in,
    input  logic [7:0]       cmd_b_in,
    input  logic [CNT_W-1:0] cmd_cnt_in,
    output logic [4:0]       alu_sel_out,
    output logic             alu_carry_out,
    output logic [7:0]       alu_a_out,
    output logic [7:0]       alu_b_out,
    input  logic [7:0]       alu_y_in,
    output logic             rsp_valid_out,
    input  logic             rsp_ready_in,
    output logic [7:0]       rsp_y_out,
    output logic             rsp_zero_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       r_state;
    logic             r_started;
    logic [4:0]       r_op;
    logic             r_carry;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_rsp_y;

    logic w_cmd_hs;
    logic w_rsp_hs;

    // r_started keeps ready low while reset is held and for the cycle it releases in.
    assign cmd_ready_out = r_started && (r_state == ST_IDLE);
    assign rsp_valid_out = (r_state == ST_RESP);
    assign w_cmd_hs      = cmd_valid_in && cmd_ready_out;
    assign w_rsp_hs      = rsp_valid_out && rsp_ready_in;

    assign alu_sel_out   = r_op;
    assign alu_carry_out = r_carry;
    assign alu_a_out     = r_a;
    assign alu_b_out     = r_b;
    assign rsp_y_out     = r_rsp_y;
    assign rsp_zero_out  = (r_rsp_y == 8'h00);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= ST_IDLE;
            r_started <= 1'b0;
            r_op      <= '0;
            r_carry   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_rsp_y   <= '0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_hs) begin
                        r_op    <= cmd_op_in;
                        r_carry <= cmd_carry_in;
                        r_a     <= cmd_a_in;
                        r_b     <= cmd_b_in;
                        r_cnt   <= cmd_cnt_in;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_a <= alu_y_in;
                    if (r_cnt == '0) begin
                        r_rsp_y <= alu_y_in;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (w_rsp_hs)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Randomized self-checking bench for alu_ctrl with a behavioural ALU and pass-count model.
module tb_alu_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       cmd_valid_in;
    logic       cmd_ready_out;
    logic [4:0] cmd_op_in;
    logic       cmd_carry_in;
    logic [7:0] cmd_a_in, cmd_b_in;
    logic [2:0] cmd_cnt_in;
    logic [4:0] alu_sel_out;
    logic       alu_carry_out;
    logic [7:0] alu_a_out, alu_b_out, alu_y_in;
    logic       rsp_valid_out;
    logic       rsp_ready_in;
    logic [7:0] rsp_y_out;
    logic       rsp_zero_out;

    int n_checks = 0;
    int n_errs   = 0;
    logic [7:0] trace[$];

    alu_ctrl #(.CNT_W(3)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .cmd_op_in(cmd_op_in), .cmd_carry_in(cmd_carry_in),
        .cmd_a_in(cmd_a_in), .cmd_b_in(cmd_b_in), .cmd_cnt_in(cmd_cnt_in),
        .alu_sel_out(alu_sel_out), .alu_carry_out(alu_carry_out),
        .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_y_in(alu_y_in),
        .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
        .rsp_y_out(rsp_y_out), .rsp_zero_out(rsp_zero_out)
    );

    always #5 clk_in = ~clk_in;

    // External ALU: sel = {shift[1:0], logic/arith, op[1:0]}
    function automatic logic [7:0] alu_f(input logic [4:0] sel, input logic c,
                                         input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        if (!sel[2]) begin
            case (sel[1:0])
                2'd0: r = a + {7'd0, c};
                2'd1: r = a - b - {7'd0, ~c};
                2'd2: r = a + b + {7'd0, c};
                default: r = a - b;
            endcase
        end else begin
            case (sel[1:0])
                2'd0: r = a & b;
                2'd1: r = a | b;
                2'd2: r = a ^ b;
                default: r = ~a;
            endcase
        end
        case (sel[4:3])
            2'd1: r = {r[6:0], 1'b0};
            2'd2: r = {1'b0, r[7:1]};
            2'd3: r = {r[6:0], r[7]};
            default: ;
        endcase
        return r;
    endfunction

    assign alu_y_in = alu_f(alu_sel_out, alu_carry_out, alu_a_out, alu_b_out);

    // Reference: cnt+1 passes with the result fed back as A each pass.
    function automatic logic [7:0] ref_run(input logic [4:0] op, input logic c,
                                           input logic [7:0] a, input logic [7:0] b,
                                           input int cnt);
        logic [7:0] acc = a;
        for (int p = 0; p <= cnt; p++) acc = alu_f(op, c, acc, b);
        return acc;
    endfunction

    // Drives one command from a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input logic [4:0] op, input logic c, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] cnt);
        int waited = 0;
        cmd_valid_in = 1'b1; cmd_op_in = op; cmd_carry_in = c;
        cmd_a_in = a; cmd_b_in = b; cmd_cnt_in = cnt;
        while (!cmd_ready_out && waited < 20) begin
            @(posedge clk_in); @(negedge clk_in); waited++;
        end
        n_checks++;
        if (!cmd_ready_out) begin
            n_errs++;
            $display("FAIL accept_timeout: ready=%b required 1", cmd_ready_out);
        end
        @(posedge clk_in);
        @(negedge clk_in);
        cmd_valid_in = 1'b0;
    endtask

    // Counts edges until rsp_valid_out, recording alu_a_out each EXEC cycle.
    task automatic wait_rsp(output int lat);
        lat = 0;
        trace.delete();
        while (!rsp_valid_out && lat < 40) begin
            trace.push_back(alu_a_out);
            @(posedge clk_in); @(negedge clk_in); lat++;
        end
    endtask

    task automatic consume();
        rsp_ready_in = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        rsp_ready_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; cmd_valid_in = 0; rsp_ready_in = 0;
        cmd_op_in = 0; cmd_carry_in = 0; cmd_a_in = 0; cmd_b_in = 0; cmd_cnt_in = 0;
        #3;
        n_checks++;
        if ({alu_sel_out, alu_carry_out, alu_a_out, alu_b_out, rsp_valid_out, rsp_y_out} !== '0) begin
            n_errs++;
            $display("FAIL reset_outputs: sel=%h c=%b a=%h b=%h v=%b y=%h required all 0",
                     alu_sel_out, alu_carry_out, alu_a_out, alu_b_out, rsp_valid_out, rsp_y_out);
        end
        n_checks++;
        if (cmd_ready_out !== 1'b0 || rsp_zero_out !== 1'b1) begin
            n_errs++;
            $display("FAIL reset_ready_zero: ready=%b zero=%b required 0/1", cmd_ready_out, rsp_zero_out);
        end
        @(negedge clk_in); rst_n_in = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        n_checks++;
        if (cmd_ready_out !== 1'b1) begin
            n_errs++;
            $display("FAIL reset_release_ready: got %b required 1", cmd_ready_out);
        end
    endtask

    task automatic test_add();
        int lat;
        accept(5'b00010, 1'b0, 8'h3C, 8'h11, 3'd0);
        wait_rsp(lat);
        n_checks++;
        if (lat !== 1 || rsp_y_out !== 8'h4D || rsp_zero_out !== 1'b0) begin
            n_errs++;
            $display("FAIL add: lat=%0d y=%h zero=%b required 1/4d/0", lat, rsp_y_out, rsp_zero_out);
        end
        consume();
        n_checks++;
        if (rsp_valid_out !== 1'b0 || cmd_ready_out !== 1'b1 || rsp_y_out !== 8'h4D) begin
            n_errs++;
            $display("FAIL add_handshake: v=%b ready=%b y=%h required 0/1/4d",
                     rsp_valid_out, cmd_ready_out, rsp_y_out);
        end
    endtask

    task automatic test_shift();
        int lat;
        logic [7:0] exp_tr[4] = '{8'h01, 8'h02, 8'h04, 8'h08};
        accept(5'b01000, 1'b0, 8'h01, 8'h00, 3'd3);
        wait_rsp(lat);
        n_checks++;
        if (lat !== 4 || rsp_y_out !== 8'h10) begin
            n_errs++;
            $display("FAIL shift: lat=%0d y=%h required 4/10", lat, rsp_y_out);
        end
        n_checks++;
        if (trace.size() != 4) begin
            n_errs++;
            $display("FAIL shift_trace_len: got %0d required 4", trace.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (trace[i] !== exp_tr[i]) begin
                    n_errs++;
                    $display("FAIL shift_trace[%0d]: got %h required %h", i, trace[i], exp_tr[i]);
                end
            end
        end
        consume();
    endtask

    task automatic test_wrap();
        int lat;
        accept(5'b00000, 1'b1, 8'hFE, 8'h00, 3'd1);
        wait_rsp(lat);
        n_checks++;
        if (lat !== 2 || rsp_y_out !== 8'h00 || rsp_zero_out !== 1'b1) begin
            n_errs++;
            $display("FAIL wrap: lat=%0d y=%h zero=%b required 2/00/1", lat, rsp_y_out, rsp_zero_out);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] exp2;
        accept(5'b00100, 1'b0, 8'hF0, 8'hFF, 3'd0);
        wait_rsp(lat);
        cmd_valid_in = 1'b1; cmd_op_in = 5'b00010; cmd_carry_in = 1'b0;
        cmd_a_in = 8'h05; cmd_b_in = 8'h07; cmd_cnt_in = 3'd2;
        exp2 = ref_run(5'b00010, 1'b0, 8'h05, 8'h07, 2);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rsp_valid_out !== 1'b1 || rsp_y_out !== 8'hF0 || cmd_ready_out !== 1'b0) begin
                n_errs++;
                $display("FAIL backpressure[%0d]: v=%b y=%h ready=%b required 1/f0/0",
                         i, rsp_valid_out, rsp_y_out, cmd_ready_out);
            end
            @(posedge clk_in); @(negedge clk_in);
        end
        consume();
        n_checks++;
        if (rsp_valid_out !== 1'b0 || cmd_ready_out !== 1'b1 || alu_a_out !== 8'hF0) begin
            n_errs++;
            $display("FAIL turnaround: v=%b ready=%b a=%h required 0/1/f0 (no same-edge accept)",
                     rsp_valid_out, cmd_ready_out, alu_a_out);
        end
        @(posedge clk_in); @(negedge clk_in);
        cmd_valid_in = 1'b0;
        n_checks++;
        if (cmd_ready_out !== 1'b0 || alu_a_out !== 8'h05) begin
            n_errs++;
            $display("FAIL second_accept: ready=%b a=%h required 0/05", cmd_ready_out, alu_a_out);
        end
        wait_rsp(lat);
        n_checks++;
        if (lat !== 3 || rsp_y_out !== exp2) begin
            n_errs++;
            $display("FAIL second_result: lat=%0d y=%h required 3/%h", lat, rsp_y_out, exp2);
        end
        consume();
    endtask

    task automatic test_random();
        int lat, dly;
        logic [4:0] op; logic c; logic [7:0] a, b, exp; logic [2:0] cnt;
        for (int t = 0; t < 30; t++) begin
            op = 5'($urandom); c = 1'($urandom); a = 8'($urandom);
            b = 8'($urandom); cnt = 3'($urandom);
            if (t % 7 == 0) begin op = 5'b00011; b = a; cnt = 3'd0; end
            exp = ref_run(op, c, a, b, int'(cnt));
            accept(op, c, a, b, cnt);
            wait_rsp(lat);
            n_checks++;
            if (lat !== int'(cnt) + 1 || rsp_y_out !== exp || rsp_zero_out !== (exp == 8'h00)) begin
                n_errs++;
                $display("FAIL random[%0d] op=%b: lat=%0d y=%h zero=%b required %0d/%h/%b",
                         t, op, lat, rsp_y_out, rsp_zero_out, int'(cnt) + 1, exp, exp == 8'h00);
            end
            dly = $urandom_range(0, 3);
            for (int d = 0; d < dly; d++) begin
                @(posedge clk_in); @(negedge clk_in);
                n_checks++;
                if (rsp_valid_out !== 1'b1 || rsp_y_out !== exp) begin
                    n_errs++;
                    $display("FAIL random_hold[%0d]: v=%b y=%h required 1/%h", t, rsp_valid_out, rsp_y_out, exp);
                end
            end
            consume();
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        accept(5'b00010, 1'b1, 8'h21, 8'h13, 3'd7);
        for (int i = 0; i < 3; i++) @(posedge clk_in);
        @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        n_checks++;
        if ({alu_sel_out, alu_carry_out, alu_a_out, alu_b_out, rsp_valid_out, rsp_y_out, cmd_ready_out} !== '0
            || rsp_zero_out !== 1'b1) begin
            n_errs++;
            $display("FAIL reset_mid: sel=%h c=%b a=%h b=%h v=%b y=%h ready=%b zero=%b required 0s/zero=1",
                     alu_sel_out, alu_carry_out, alu_a_out, alu_b_out, rsp_valid_out, rsp_y_out,
                     cmd_ready_out, rsp_zero_out);
        end
        @(negedge clk_in); rst_n_in = 1'b1;
        n_checks++;
        if (cmd_ready_out !== 1'b0) begin
            n_errs++;
            $display("FAIL reset_mid_release: ready=%b required 0 before first edge", cmd_ready_out);
        end
        @(posedge clk_in); @(negedge clk_in);
        n_checks++;
        if (cmd_ready_out !== 1'b1) begin
            n_errs++;
            $display("FAIL reset_mid_ready: got %b required 1", cmd_ready_out);
        end
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid_out === 1'b1) seen++;
            @(posedge clk_in); @(negedge clk_in);
        end
        n_checks++;
        if (seen != 0) begin
            n_errs++;
            $display("FAIL reset_mid_no_rsp: saw valid %0d cycles required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_add();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: CNT_W, default 3, width of the pass-count field; up to 2**CNT_W passes per command.
REQ-002 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid_in  input  1  command request.
REQ-005 cmd_ready_out  output  1  command accepted when cmd_valid_in and cmd_ready_out are both high on a rising edge.
REQ-006 cmd_op_in  input  5  ALU select code {shift[1:0], logic/arith, op[1:0]}.
REQ-007 cmd_carry_in  input  1  ALU carry-in for the command.
REQ-008 cmd_a_in, cmd_b_in  input  8 each  operands A and B.
REQ-009 cmd_cnt_in  input  CNT_W  number of ALU passes minus one.
REQ-010 alu_sel_out  output  5  select code to the external combinational ALU.
REQ-011 alu_carry_out  output  1  carry-in to the ALU.
REQ-012 alu_a_out, alu_b_out  output  8 each  operands to the ALU.
REQ-013 alu_y_in  input  8  ALU result, combinational from the alu_* outputs.
REQ-014 rsp_valid_out  output  1  result available.
REQ-015 rsp_ready_in  input  1  result consumed when rsp_valid_out and rsp_ready_in are both high on a rising edge.
REQ-016 rsp_y_out  output  8  final result.
REQ-017 rsp_zero_out  output  1  high when rsp_y_out == 8'h00.

Function
REQ-018 FSM states: IDLE, EXEC, RESP; exactly one state active at a time.
REQ-019 IDLE: cmd_ready_out=1; on cmd handshake latch op, carry, A, B, cnt into internal registers; next state EXEC.
REQ-020 cmd_ready_out SHALL be 0 in EXEC and RESP; cmd_valid_in is ignored there, with no queuing.
REQ-021 alu_sel_out, alu_carry_out, alu_a_out and alu_b_out SHALL be driven directly from the internal op, carry, A and B registers in all states.
REQ-022 EXEC, each cycle: A register <= alu_y_in; pass counter decrements; op, carry and B are held constant.
REQ-023 EXEC exit: on the edge where the pass counter equals 0, rsp_y_out <= alu_y_in; next state RESP.
REQ-024 Latency: rsp_valid_out SHALL rise exactly cnt+1 edges after the accepting edge (cnt=0 gives 1 edge; cnt=7 gives 8 edges).
REQ-025 RESP: rsp_valid_out=1; rsp_y_out and rsp_zero_out are stable until the handshake; on handshake next state IDLE.
REQ-026 No same-cycle turnaround: after a response handshake, cmd_ready_out rises on the following cycle.
REQ-027 rsp_y_out SHALL retain its value after the handshake until the next command's EXEC exit.
REQ-028 Arithmetic is modulo 2**8 as produced by the ALU; alu_ctrl adds no width extension or carry-out.
REQ-029 rsp_zero_out SHALL be derived from the registered rsp_y_out, never from alu_y_in.

Reset
REQ-030 Assertion of rst_n_in SHALL immediately force IDLE and clear every register to 0: all alu_* outputs = 0, rsp_valid_out = 0, rsp_y_out = 8'h00, pass counter = 0.
REQ-031 During reset, cmd_ready_out = 0 and rsp_zero_out = 1.
REQ-032 cmd_ready_out SHALL rise on the first rising edge after deassertion.
REQ-033 Reset during EXEC or RESP SHALL discard the in-flight command; no response is produced for it.

Verification
REQ-034 Add, op=00010, carry=0, A=8'h3C, B=8'h11, cnt=0 -> rsp_valid_out 1 edge after accept; rsp_y_out=8'h4D; rsp_zero_out=0.
REQ-035 Shift left, op=01000, A=8'h01, cnt=3 -> 4 passes; rsp_y_out=8'h10 on edge 4; alu_a_out shows 01, 02, 04, 08 across EXEC.
REQ-036 Increment wrap, op=00000, carry=1, A=8'hFE, cnt=1 -> rsp_y_out=8'h00; rsp_zero_out=1.
REQ-037 Backpressure: complete an AND command, op=00100, A=8'hF0, B=8'hFF, then hold rsp_ready_in=0 for 5 cycles while driving cmd_valid_in=1 -> rsp_valid_out held; rsp_y_out=8'hF0 stable; cmd_ready_out=0; the second command is accepted only after the response handshake plus 1 cycle.
REQ-038 Reset mid-EXEC with cnt=7 after 3 passes -> all outputs 0 at once; no rsp_valid_out ever appears for that command; cmd_ready_out=1 one edge after release.
